// File: rtl/page_scheduler_if.sv
// rtl/page_scheduler_if.sv - shared page bus between the page scheduler and the page modules
// Scheduler drives the master side; pages and the display front end sit on the slave side.
interface page_scheduler_if #(
  parameter int N_PAGES = 4,
  parameter int IDX_W   = $clog2(N_PAGES),
  parameter int UI_W    = 8,
  parameter int TEXT_W  = 32
);
  logic [UI_W-1:0]                 user_in;
  logic [N_PAGES-1:0][IDX_W-1:0]   page_state;
  logic [N_PAGES-1:0][TEXT_W-1:0]  page_text;
  logic [N_PAGES-1:0]              page_rst;
  logic [N_PAGES-1:0][UI_W-1:0]    page_in;
  logic [IDX_W-1:0]                cur_state;
  logic [TEXT_W-1:0]               screen;
  logic                            busy;
  logic                            err;

  modport master (
    input  user_in, page_state, page_text,
    output page_rst, page_in, cur_state, screen, busy, err
  );

  modport slave (
    output user_in, page_state, page_text,
    input  page_rst, page_in, cur_state, screen, busy, err
  );
endinterface

// File: rtl/page_scheduler.sv
// rtl/page_scheduler.sv - owns the current TopState and hands the screen and user input to one page at a time
// A switch runs ENTER -> CLEAR -> RELEASE -> ACTIVE so the new page starts clean on a blank screen.
module page_scheduler #(
  parameter int N_PAGES      = 4,
  parameter int CLEAR_CYCLES = 2,
  parameter int IDX_W        = $clog2(N_PAGES),
  parameter int UI_W         = 8,
  parameter int TEXT_W       = 32
) (
  input  logic             clk,
  input  logic             prog_clk,
  input  logic             rst,
  page_scheduler_if.master bus
);
  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [IDX_W:0] N_PAGES_EXT = (IDX_W + 1)'(N_PAGES);

  typedef enum logic [1:0] {ENTER, CLEAR, RELEASE, ACTIVE} state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           target_q, target_d;
  logic [IDX_W-1:0]           cur_state_q, cur_state_d;
  logic [N_PAGES-1:0]         page_rst_q, page_rst_d;
  logic [TEXT_W-1:0]          screen_q, screen_d;
  logic                       err_q, err_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           req;
  logic [N_PAGES-1:0][UI_W-1:0] page_in_c;
  logic                       unused_clk;

  assign unused_clk = clk;
  // Only the granted page may ask for a new TopState.
  assign req = bus.page_state[cur_state_q];

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    cur_state_d = cur_state_q;
    page_rst_d  = '0;
    screen_d    = '0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    page_in_c   = '0;
    case (state_q)
      ENTER: begin
        cur_state_d = target_q;
        page_rst_d  = N_PAGES'(1) << target_q;
        screen_d    = screen_q;
        cnt_d       = '0;
        state_d     = CLEAR;
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) state_d = RELEASE;
      end
      RELEASE: begin
        // Keeps the key that caused the switch from reaching the new page.
        if (bus.user_in == '0) state_d = ACTIVE;
      end
      ACTIVE: begin
        screen_d                = bus.page_text[cur_state_q];
        page_in_c[cur_state_q]  = bus.user_in;
        if (req != cur_state_q) begin
          if ({1'b0, req} < N_PAGES_EXT) begin
            target_d = req;
            state_d  = ENTER;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ENTER;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (rst) begin
      state_q     <= ENTER;
      target_q    <= '0;
      cur_state_q <= '0;
      page_rst_q  <= '0;
      screen_q    <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      cur_state_q <= cur_state_d;
      page_rst_q  <= page_rst_d;
      screen_q    <= screen_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.page_rst  = page_rst_q;
  assign bus.page_in   = page_in_c;
  assign bus.cur_state = cur_state_q;
  assign bus.screen    = screen_q;
  assign bus.busy      = (state_q != ACTIVE);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_page_scheduler.sv
// tb/tb_page_scheduler.sv - bench for page_scheduler
// Directed vector table, hand-written switch corner cases, then random traffic against a reference model.
module tb_page_scheduler;
  localparam int NP  = 4;
  localparam int IW  = 3;
  localparam int CLR = 2;

  logic clk = 1'b0;
  logic prog_clk = 1'b0;
  logic rst = 1'b1;

  always #7 clk = ~clk;
  always #5 prog_clk = ~prog_clk;

  page_scheduler_if #(.N_PAGES(NP), .IDX_W(IW), .UI_W(8), .TEXT_W(32)) bus ();

  page_scheduler #(.N_PAGES(NP), .CLEAR_CYCLES(CLR), .IDX_W(IW), .UI_W(8), .TEXT_W(32)) dut (
    .clk      (clk),
    .prog_clk (prog_clk),
    .rst      (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: m_seq < 0 means a page owns the UI; otherwise it counts
  // cycles since the switch began (0 = re-init, 1..CLR = blank, beyond = wait for key release).
  int          m_seq = 0;
  int          m_cur = 0;
  int          m_target = 0;
  logic        m_err = 1'b0;
  logic [31:0] m_screen = 32'h0;
  logic [3:0]  m_prst = 4'h0;

  typedef struct packed {
    logic        r;
    logic [7:0]  ui;
    logic [2:0]  ps0;
    logic [2:0]  ps1;
    logic [2:0]  ps2;
    logic [2:0]  cur;
    logic        busy;
    logic [3:0]  prst;
    logic [31:0] scr;
    logic [31:0] pin;
    logic        err;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] txt(input int i);
    return 32'h7E57_0000 | 32'(i);
  endfunction

  task automatic model_update(input logic r);
    int req;
    if (r) begin
      m_seq = 0; m_target = 0; m_cur = 0; m_prst = 4'h0; m_screen = 32'h0; m_err = 1'b0;
    end else if (m_seq < 0) begin
      m_prst   = 4'h0;
      m_screen = bus.page_text[m_cur];
      req      = int'(bus.page_state[m_cur]);
      if (req != m_cur) begin
        if (req < NP) begin
          m_target = req;
          m_seq    = 0;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (m_seq == 0) begin
      m_cur  = m_target;
      m_prst = 4'(1 << m_target);
      m_seq  = 1;
    end else if (m_seq <= CLR) begin
      m_prst   = 4'h0;
      m_screen = 32'h0;
      m_seq++;
    end else begin
      m_prst   = 4'h0;
      m_screen = 32'h0;
      if (bus.user_in == 8'h0) m_seq = -1;
    end
  endtask

  task automatic tick(input logic r, input logic [7:0] ui);
    rst = r;
    bus.user_in = ui;
    @(posedge prog_clk);
    model_update(r);
    #1;
  endtask

  task automatic check_model();
    logic [31:0] epin;
    epin = (m_seq < 0) ? (32'(bus.user_in) << (8 * m_cur)) : 32'h0;
    chk("model_cur", 32'(bus.cur_state), 32'(m_cur));
    chk("model_busy", 32'(bus.busy), 32'(m_seq >= 0));
    chk("model_page_rst", 32'(bus.page_rst), 32'(m_prst));
    chk("model_screen", bus.screen, m_screen);
    chk("model_page_in", bus.page_in, epin);
    chk("model_err", 32'(bus.err), 32'(m_err));
  endtask

  task automatic set_ps(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
    bus.page_state[0] = a;
    bus.page_state[1] = b;
    bus.page_state[2] = c;
    bus.page_state[3] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    logic granted2;
    bus.user_in = 8'h0;
    set_ps(3'd0, 3'd1, 3'd2, 3'd3);
    for (int i = 0; i < NP; i++) bus.page_text[i] = txt(i);

    //          r  ui     ps0   ps1   ps2 | cur  busy prst     screen   page_in       err
    tbl[0]  = '{1'b1, 8'h00, 3'd0, 3'd1, 3'd2, 3'd0, 1'b1, 4'b0000, 32'h0,   32'h0,        1'b0};
    tbl[1]  = '{1'b0, 8'h00, 3'd0, 3'd1, 3'd2, 3'd0, 1'b1, 4'b0001, 32'h0,   32'h0,        1'b0};
    tbl[2]  = '{1'b0, 8'h00, 3'd0, 3'd1, 3'd2, 3'd0, 1'b1, 4'b0000, 32'h0,   32'h0,        1'b0};
    tbl[3]  = '{1'b0, 8'h00, 3'd0, 3'd1, 3'd2, 3'd0, 1'b1, 4'b0000, 32'h0,   32'h0,        1'b0};
    tbl[4]  = '{1'b0, 8'h00, 3'd0, 3'd1, 3'd2, 3'd0, 1'b0, 4'b0000, 32'h0,   32'h0,        1'b0};
    tbl[5]  = '{1'b0, 8'h00, 3'd0, 3'd1, 3'd2, 3'd0, 1'b0, 4'b0000, txt(0),  32'h0,        1'b0};
    tbl[6]  = '{1'b0, 8'h01, 3'd0, 3'd1, 3'd2, 3'd0, 1'b0, 4'b0000, txt(0),  32'h0000_0001, 1'b0};
    tbl[7]  = '{1'b0, 8'h01, 3'd1, 3'd1, 3'd2, 3'd0, 1'b1, 4'b0000, txt(0),  32'h0,        1'b0};
    tbl[8]  = '{1'b0, 8'h01, 3'd1, 3'd1, 3'd2, 3'd1, 1'b1, 4'b0010, txt(0),  32'h0,        1'b0};
    tbl[9]  = '{1'b0, 8'h01, 3'd1, 3'd1, 3'd2, 3'd1, 1'b1, 4'b0000, 32'h0,   32'h0,        1'b0};
    tbl[10] = '{1'b0, 8'h01, 3'd1, 3'd1, 3'd2, 3'd1, 1'b1, 4'b0000, 32'h0,   32'h0,        1'b0};
    tbl[11] = '{1'b0, 8'h01, 3'd1, 3'd1, 3'd2, 3'd1, 1'b1, 4'b0000, 32'h0,   32'h0,        1'b0};
    tbl[12] = '{1'b0, 8'h00, 3'd1, 3'd1, 3'd2, 3'd1, 1'b0, 4'b0000, 32'h0,   32'h0,        1'b0};
    tbl[13] = '{1'b0, 8'h00, 3'd1, 3'd1, 3'd2, 3'd1, 1'b0, 4'b0000, txt(1),  32'h0,        1'b0};
    tbl[14] = '{1'b0, 8'h05, 3'd1, 3'd1, 3'd3, 3'd1, 1'b0, 4'b0000, txt(1),  32'h0000_0500, 1'b0};
    tbl[15] = '{1'b0, 8'h05, 3'd1, 3'd5, 3'd3, 3'd1, 1'b0, 4'b0000, txt(1),  32'h0000_0500, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 3'd1, 3'd1, 3'd3, 3'd1, 1'b0, 4'b0000, txt(1),  32'h0,        1'b1};

    for (int i = 0; i < 17; i++) begin
      set_ps(tbl[i].ps0, tbl[i].ps1, tbl[i].ps2, 3'd3);
      tick(tbl[i].r, tbl[i].ui);
      chk($sformatf("vec%0d_cur", i), 32'(bus.cur_state), 32'(tbl[i].cur));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_page_rst", i), 32'(bus.page_rst), 32'(tbl[i].prst));
      chk($sformatf("vec%0d_screen", i), bus.screen, tbl[i].scr);
      chk($sformatf("vec%0d_page_in", i), bus.page_in, tbl[i].pin);
      chk($sformatf("vec%0d_err", i), 32'(bus.err), 32'(tbl[i].err));
    end

    // Reset while blanking toward page 2: page 2 must never own the UI.
    set_ps(3'd0, 3'd2, 3'd2, 3'd3);
    tick(1'b0, 8'h00);
    chk("mid_enter_busy", 32'(bus.busy), 32'd1);
    set_ps(3'd0, 3'd1, 3'd2, 3'd3);
    tick(1'b0, 8'h00);
    chk("mid_clear_page_rst", 32'(bus.page_rst), 32'b0100);
    tick(1'b1, 8'h00);
    chk("mid_rst_cur", 32'(bus.cur_state), 32'd0);
    chk("mid_rst_err", 32'(bus.err), 32'd0);
    tick(1'b0, 8'h00);
    chk("mid_rst_page_rst", 32'(bus.page_rst), 32'b0001);
    chk("mid_rst_cur2", 32'(bus.cur_state), 32'd0);
    waited = 0;
    granted2 = 1'b0;
    while (bus.busy && waited < 20) begin
      tick(1'b0, 8'h00);
      if (!bus.busy && bus.cur_state == 3'd2) granted2 = 1'b1;
      waited++;
    end
    chk("mid_rst_settled", 32'(waited < 20), 32'd1);
    chk("mid_rst_not_page2", 32'(granted2), 32'd0);
    chk("mid_rst_final_cur", 32'(bus.cur_state), 32'd0);
    check_model();

    // Key held for 10 cycles after a switch request: no input leaks anywhere.
    set_ps(3'd3, 3'd1, 3'd2, 3'd3);
    tick(1'b0, 8'h10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d_busy", i), 32'(bus.busy), 32'd1);
      chk($sformatf("hold%0d_page_in", i), bus.page_in, 32'h0);
      tick(1'b0, 8'h10);
    end
    chk("hold_end_busy", 32'(bus.busy), 32'd1);
    tick(1'b0, 8'h00);
    chk("release_busy", 32'(bus.busy), 32'd0);
    chk("release_cur", 32'(bus.cur_state), 32'd3);
    check_model();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        bus.page_text[i] = $urandom;
        bus.page_state[i] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'(i);
      end
      tick(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
